// File: rtl/constant_rr_arbiter.sv
// constant_rr_arbiter: round-robin sharing of one constant source among NUM_REQ ctrl channels,
// with a one-slot registered output that refills in the same cycle it drains.
module constant_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 32,
    parameter longint unsigned CONST_VALUE = 1,
    localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ins_valid,
    output logic [NUM_REQ-1:0]    ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_next;
    logic [IDX_WIDTH-1:0] ptr, winner, j;
    logic any, load;

    assign outs = DATA_WIDTH'(CONST_VALUE);
    assign any = |ins_valid;
    assign load = (state == EMPTY) || outs_ready;

    // Scan from the farthest offset down so the nearest valid requester after ptr wins.
    always_comb begin
        winner = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (ins_valid[j]) winner = j;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= '0;
            index <= '0;
        end else begin
            state <= state_next;
            if (load && any) begin
                index <= winner;
                ptr   <= (winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = load ? (any ? FULL : EMPTY) : state;
    end

    always_comb begin
        outs_valid = (state == FULL);
        ins_ready = (load && !rst) ? ((NUM_REQ'(1) << winner) & ins_valid) : '0;
    end
endmodule

// File: tb/tb_constant_rr_arbiter.sv
// tb_constant_rr_arbiter: directed scenarios plus randomized traffic checked against
// a slot/pointer reference model of the round-robin constant arbiter.
module tb_constant_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ins_valid = '0;
    logic [3:0]  ins_ready;
    logic [31:0] outs;
    logic [1:0]  index;
    logic        outs_valid;
    logic        outs_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // reference model: slot occupancy, held token index, next-priority requester
    bit m_full = 1'b0;
    int m_idx = 0;
    int m_ptr = 0;

    constant_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .CONST_VALUE(1)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .index(index), .outs_valid(outs_valid), .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_winner(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++)
            if (((v >> ((p + k) % 4)) & 4'b1) != 4'b0) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int w;
        w = model_winner(ins_valid, m_ptr);
        if ((!m_full || outs_ready) && w >= 0) return 4'(1 << w);
        return 4'b0;
    endfunction

    task automatic drive(input logic [3:0] v, input logic r);
        @(negedge clk);
        ins_valid = v;
        outs_ready = r;
        #1;
    endtask

    task automatic tick();
        int w;
        @(posedge clk);
        w = model_winner(ins_valid, m_ptr);
        if (!m_full || outs_ready) begin
            if (w >= 0) begin
                m_full = 1'b1;
                m_idx = w;
                m_ptr = (w + 1) % 4;
            end else m_full = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ins_valid = '0;
        outs_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_full = 1'b0;
        m_idx = 0;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ins_valid = 4'b1111;
        outs_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", outs_valid); end
        checks++;
        if (ins_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", ins_ready); end
        checks++;
        if (outs !== 32'd1) begin failures++; $display("FAIL reset_outs got=%0d exp=1", outs); end
        checks++;
        if (index !== 2'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", index); end
        @(negedge clk);
        rst = 1'b0;
        m_full = 1'b0; m_idx = 0; m_ptr = 0;
        outs_ready = 1'b1;
        tick();
        drive(4'b0000, 1'b0);
        checks++;
        if (outs_valid !== 1'b1 || index !== 2'd0)
            begin failures++; $display("FAIL reset_first got=%b/%0d exp=1/0", outs_valid, index); end
        checks++;
        if (outs !== 32'd1) begin failures++; $display("FAIL outs_const got=%0d exp=1", outs); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 1'b1);
            checks++;
            if (ins_ready !== 4'(1 << (k % 4)))
                begin failures++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, ins_ready, 4'(1 << (k % 4))); end
            tick();
            #1;
            checks++;
            if (outs_valid !== 1'b1 || index !== 2'(k % 4))
                begin failures++; $display("FAIL fair_index k=%0d got=%b/%0d exp=1/%0d", k, outs_valid, index, k % 4); end
        end
    endtask

    task automatic test_skip_wrap();
        logic [3:0] exp_r [3];
        int exp_i [3];
        exp_r = '{4'b0001, 4'b0100, 4'b0001};
        exp_i = '{0, 2, 0};
        do_reset();
        drive(4'b0100, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0101, 1'b1);
            checks++;
            if (ins_ready !== exp_r[k])
                begin failures++; $display("FAIL wrap_ready k=%0d got=%b exp=%b", k, ins_ready, exp_r[k]); end
            tick();
            #1;
            checks++;
            if (index !== 2'(exp_i[k]))
                begin failures++; $display("FAIL wrap_index k=%0d got=%0d exp=%0d", k, index, exp_i[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(4'b0010, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b0);
            checks++;
            if (ins_ready !== 4'b0 || outs_valid !== 1'b1 || index !== 2'd1)
                begin failures++; $display("FAIL stall k=%0d got=%b/%b/%0d exp=0000/1/1", k, ins_ready, outs_valid, index); end
            tick();
        end
        drive(4'b1111, 1'b1);
        checks++;
        if (ins_ready !== 4'b0100) begin failures++; $display("FAIL stall_release got=%b exp=0100", ins_ready); end
        tick();
        #1;
        checks++;
        if (outs_valid !== 1'b1 || index !== 2'd2)
            begin failures++; $display("FAIL stall_next got=%b/%0d exp=1/2", outs_valid, index); end
    endtask

    task automatic test_drain();
        do_reset();
        drive(4'b0001, 1'b1);
        tick();
        drive(4'b0000, 1'b1);
        checks++;
        if (outs_valid !== 1'b1) begin failures++; $display("FAIL drain_full got=%b exp=1", outs_valid); end
        tick();
        drive(4'b0000, 1'b1);
        checks++;
        if (outs_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", outs_valid); end
        tick();
        drive(4'b0000, 1'b0);
        checks++;
        if (outs_valid !== 1'b0) begin failures++; $display("FAIL drain_stay got=%b exp=0", outs_valid); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(4'b1111, 1'b1);
        tick();
        drive(4'b1111, 1'b0);
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 4'b0)
            begin failures++; $display("FAIL async_rst got=%b/%b exp=0/0000", outs_valid, ins_ready); end
        #1;
        rst = 1'b0;
        m_full = 1'b0; m_idx = 0; m_ptr = 0;
        tick();
        #1;
        checks++;
        if (outs_valid !== 1'b1 || index !== 2'd0)
            begin failures++; $display("FAIL rst_regrant got=%b/%0d exp=1/0", outs_valid, index); end
    endtask

    task automatic test_random();
        logic [3:0] er;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
            er = model_ready();
            checks++;
            if (ins_ready !== er || outs_valid !== m_full || index !== 2'(m_idx))
                begin failures++; $display("FAIL random n=%0d got=%b/%b/%0d exp=%b/%b/%0d", n, ins_ready, outs_valid, index, er, m_full, m_idx); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_skip_wrap();
        test_backpressure();
        test_drain();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
